// File: rtl/mem_stage_lsu_if.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu_if
//   Data-memory port between the MEM-stage load/store unit and the memory.
//   The LSU is the master and issues requests. The memory is the slave and
//   answers with an ack and, for loads, read data.
//
//   Signals
//     dmem_req   : request pending, held until dmem_ack is seen.
//     dmem_we    : 1 = write (store), 0 = read (load).
//     dmem_addr  : word-aligned byte address.
//     dmem_wdata : store data, already replicated into the byte lanes.
//     dmem_be    : byte enables. Always 4'b1111 for reads.
//     dmem_ack   : memory has completed the request.
//     dmem_rdata : read word, valid together with dmem_ack.
// ----------------------------------------------------------------------------
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu
//   MEM stage of a 5-stage RISC-V pipeline. The block issues loads and stores
//   to the data memory and builds the MEM/WB register contents.
//
//   Instructions that need no memory access pass through in one cycle. An
//   aligned load or store spends one IDLE cycle launching the request, then
//   waits in ACCESS until the memory acks. The pipeline is stalled for that
//   whole time. Misaligned or illegal accesses never reach memory. Instead
//   they retire at once with wb_fault set.
//
//   Ports
//     clk, rst_n        : clock and asynchronous active-low reset.
//     mem_*             : EX/MEM pipeline register contents. The stall output
//                         keeps these stable while an access is in flight.
//     bus (master)      : data-memory request/response port.
//     stall             : holds IF, ID, EX and EX/MEM while asserted.
//     wb_*              : MEM/WB register contents.
// ----------------------------------------------------------------------------
module mem_stage_lsu (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   mem_valid,
    input  logic                   mem_MemRW,
    input  logic                   mem_RegWEn,
    input  logic [1:0]             mem_WBSel,
    input  logic [4:0]             mem_rd,
    input  logic [31:0]            mem_pc,
    input  logic [31:0]            mem_ALU_out,
    input  logic [31:0]            mem_DataB,
    input  logic [2:0]             mem_funct3,

    mem_stage_lsu_if.master        bus,

    output logic                   stall,

    output logic                   wb_valid,
    output logic                   wb_RegWEn,
    output logic [1:0]             wb_WBSel,
    output logic [4:0]             wb_rd,
    output logic [31:0]            wb_pc4,
    output logic [31:0]            wb_ALU_out,
    output logic [31:0]            wb_mem_data,
    output logic                   wb_fault
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  w_addr_lo;
    logic        w_is_store;
    logic        w_is_load;
    logic        w_is_memop;
    logic        w_fault;
    logic        w_go;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_be;
    logic [31:0] w_ld_lane;
    logic [31:0] w_ld_data;

    // ------------------------------------------------------------------
    // Instruction classification and fault detection
    // ------------------------------------------------------------------
    assign w_addr_lo  = mem_ALU_out[1:0];
    assign w_is_store = mem_valid & mem_MemRW;
    assign w_is_load  = mem_valid & ~mem_MemRW & (mem_WBSel == 2'd0);
    assign w_is_memop = w_is_store | w_is_load;

    // funct3[1:0] encodes the access size (00 byte, 01 half, 10 word) for both
    // loads and stores, so one alignment check covers both directions.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first.
        // Without it, a missed branch would infer a latch.
        w_fault = 1'b0;
        if (w_is_memop) begin
            if (w_is_store && (mem_funct3 > 3'd2))
                w_fault = 1'b1;
            if (w_is_load && ((mem_funct3 == 3'd3) || (mem_funct3 == 3'd6) ||
                              (mem_funct3 == 3'd7)))
                w_fault = 1'b1;
            if ((mem_funct3[1:0] == 2'b01) && w_addr_lo[0])
                w_fault = 1'b1;
            if ((mem_funct3[1:0] == 2'b10) && (w_addr_lo != 2'b00))
                w_fault = 1'b1;
        end
    end

    // An aligned, legal memory operation that must go to the memory.
    assign w_go = w_is_memop & ~w_fault;

    // Gate with rst_n. While reset holds the state at IDLE, a waiting memory op
    // would otherwise still raise stall.
    assign stall = rst_n & (((r_state == IDLE)   & w_go) |
                            ((r_state == ACCESS) & ~bus.dmem_ack));

    // ------------------------------------------------------------------
    // Store lane formation
    // ------------------------------------------------------------------
    always_comb begin
        w_st_wdata = mem_DataB;
        w_st_be    = 4'b1111;
        case (mem_funct3)
            3'b000: begin
                w_st_wdata = {4{mem_DataB[7:0]}};
                w_st_be    = 4'b0001 << w_addr_lo;
            end
            3'b001: begin
                w_st_wdata = {2{mem_DataB[15:0]}};
                w_st_be    = 4'b0011 << w_addr_lo;
            end
            default: begin
                w_st_wdata = mem_DataB;
                w_st_be    = 4'b1111;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------
    assign w_ld_lane = bus.dmem_rdata >> {w_addr_lo, 3'b000};

    always_comb begin
        w_ld_data = 32'd0;
        case (mem_funct3)
            3'b000:  w_ld_data = {{24{w_ld_lane[7]}},  w_ld_lane[7:0]};
            3'b001:  w_ld_data = {{16{w_ld_lane[15]}}, w_ld_lane[15:0]};
            3'b010:  w_ld_data = w_ld_lane;
            3'b100:  w_ld_data = {24'd0, w_ld_lane[7:0]};
            3'b101:  w_ld_data = {16'd0, w_ld_lane[15:0]};
            default: w_ld_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments. All flops
        // then update together from pre-edge values, with no ordering races.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // dmem_ack in IDLE is deliberately not looked at.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_go)         w_state_next = ACCESS;
            ACCESS:  if (bus.dmem_ack) w_state_next = IDLE;
            default:                   w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory request and MEM/WB registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= 32'd0;
            bus.dmem_wdata <= 32'd0;
            bus.dmem_be    <= 4'd0;
            wb_valid       <= 1'b0;
            wb_RegWEn      <= 1'b0;
            wb_WBSel       <= 2'd0;
            wb_rd          <= 5'd0;
            wb_pc4         <= 32'd0;
            wb_ALU_out     <= 32'd0;
            wb_mem_data    <= 32'd0;
            wb_fault       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        // Launch the access. MEM/WB receives a bubble.
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= mem_MemRW;
                        bus.dmem_addr  <= {mem_ALU_out[31:2], 2'b00};
                        bus.dmem_wdata <= mem_MemRW ? w_st_wdata : 32'd0;
                        bus.dmem_be    <= mem_MemRW ? w_st_be : 4'b1111;
                        wb_valid       <= 1'b0;
                        wb_RegWEn      <= 1'b0;
                        wb_fault       <= 1'b0;
                    end else begin
                        // Single-cycle retire: pass-through, fault or empty slot.
                        wb_valid    <= mem_valid;
                        wb_RegWEn   <= mem_RegWEn & ~w_fault;
                        wb_WBSel    <= mem_WBSel;
                        wb_rd       <= mem_rd;
                        wb_pc4      <= mem_pc + 32'd4;
                        wb_ALU_out  <= mem_ALU_out;
                        wb_mem_data <= 32'd0;
                        wb_fault    <= w_fault;
                    end
                end
                ACCESS: begin
                    if (bus.dmem_ack) begin
                        bus.dmem_req <= 1'b0;
                        bus.dmem_we  <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_RegWEn    <= mem_RegWEn;
                        wb_WBSel     <= mem_WBSel;
                        wb_rd        <= mem_rd;
                        wb_pc4       <= mem_pc + 32'd4;
                        wb_ALU_out   <= mem_ALU_out;
                        wb_mem_data  <= w_is_load ? w_ld_data : 32'd0;
                        wb_fault     <= 1'b0;
                    end else begin
                        // dmem_* hold their values. MEM/WB keeps receiving bubbles.
                        wb_valid  <= 1'b0;
                        wb_RegWEn <= 1'b0;
                        wb_fault  <= 1'b0;
                    end
                end
                default: begin
                    bus.dmem_req <= 1'b0;
                    wb_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule
